hv_cmd_fetch: RTL and testbench



---
 rtl/hv_cmd_pkg.sv | 28 ++
 rtl/hv_cdb_chksum.sv | 29 ++
 rtl/hv_cmd_fetch.sv | 166 ++++++++++++++++
 tb/tb_hv_cmd_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hv_cmd_pkg.sv
// hv_cmd_pkg: shared definitions for the command path (hv_commandQ,
// hv_cmd_fetch, host-side CDB builder).
//   - CDB geometry and field offsets
//   - BSM opcodes
//   - command status codes written back on op_index/cmd_op_status
package hv_cmd_pkg;

    // CDB geometry: 256 bits delivered as 4 beats, checksum lives in word 4
    localparam int CDB_W     = 256;
    localparam int CDB_BEATS = 4;
    localparam int CHK_WORD  = 4;
    localparam int OPC_LSB   = 0;
    localparam int TAG_LSB   = 8;
    localparam int FIELD_W   = 8;

    // Opcodes
    localparam logic [7:0] OP_BSM_WRITE = 8'h40;
    localparam logic [7:0] OP_BSM_READ  = 8'h30;
    localparam logic [7:0] OP_QUERY     = 8'h70;

    // Status codes
    localparam logic [7:0] CMD_ST_NONE       = 8'd0;
    localparam logic [7:0] CMD_ST_READ_DONE  = 8'd6;
    localparam logic [7:0] CMD_ST_WRITE_DONE = 8'd7;
    localparam logic [7:0] CMD_ST_READY2FREE = 8'd12;
    localparam logic [7:0] CMD_ST_CHKSUM_ERR = 8'd13;

endpackage

// File: rtl/hv_cdb_chksum.sv
// hv_cdb_chksum: combinational CDB checksum.
// Each byte lane of the expected value is the XOR of that lane over every
// 32-bit word except the checksum word; a 32-bit XOR does all lanes at once.
// Ports:
//   cdb_i   in  CDB_W_P : full CDB
//   chk_o   out 32      : expected checksum
//   match_o out 1       : expected checksum equals the stored checksum word
module hv_cdb_chksum
    import hv_cmd_pkg::*;
#(
    parameter int CDB_W_P = CDB_W
) (
    input  logic [CDB_W_P-1:0] cdb_i,
    output logic [31:0]        chk_o,
    output logic               match_o
);

    localparam int NWORDS = CDB_W_P / 32;

    always_comb begin
        chk_o = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (w != CHK_WORD) chk_o = chk_o ^ cdb_i[w*32 +: 32];
        end
    end

    assign match_o = (chk_o == cdb_i[CHK_WORD*32 +: 32]);

endmodule

// File: rtl/hv_cmd_fetch.sv
// hv_cmd_fetch: pulls commands out of hv_commandQ, deserializes the 4-beat
// CDB, verifies the checksum and hands the command downstream. Also writes
// completion status (downstream reports or checksum errors) back to the queue.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cq_cout_ready              : queue has a command to issue
//   cmd_request                : one-cycle fetch pulse
//   cmd_oe, cmd_out            : CDB beat valid / data (beat 0 first)
//   op_index, cmd_op_status    : registered one-cycle status write
//   dec_valid/ready, dec_*     : decoded command handshake and fields
//   done_valid/tag/status      : completion report from downstream
//   done_ready                 : completion report accepted this cycle
//   timeout                    : one-cycle pulse when a fetch is abandoned
module hv_cmd_fetch
    import hv_cmd_pkg::*;
#(
    parameter int CMD_IO_WIDTH = 64,
    parameter int OE_TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cq_cout_ready,
    output logic                      cmd_request,
    input  logic                      cmd_oe,
    input  logic [CMD_IO_WIDTH-1:0]   cmd_out,
    output logic [7:0]                op_index,
    output logic [7:0]                cmd_op_status,
    output logic                      dec_valid,
    input  logic                      dec_ready,
    output logic [7:0]                dec_opcode,
    output logic [7:0]                dec_tag,
    output logic [4*CMD_IO_WIDTH-1:0] dec_cdb,
    input  logic                      done_valid,
    input  logic [7:0]                done_tag,
    input  logic [7:0]                done_status,
    output logic                      done_ready,
    output logic                      timeout
);

    localparam int CDBW = CDB_BEATS * CMD_IO_WIDTH;
    localparam int TW   = $clog2(OE_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_REQ     = 3'd1;
    localparam logic [2:0] S_WAIT_OE = 3'd2;
    localparam logic [2:0] S_CAP     = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_PRESENT = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      beat_q, beat_d;
    logic [CDBW-1:0] cdb_q, cdb_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      st_q, st_d;
    logic            chk_match;
    logic [31:0]     chk_unused;   // expected value only matters to the host-side builder
    logic            err_pending;
    logic            tmo_hit;

    hv_cdb_chksum #(.CDB_W_P(CDBW)) u_chk (
        .cdb_i   (cdb_q),
        .chk_o   (chk_unused),
        .match_o (chk_match)
    );

    // Checksum error is raised in the CHECK cycle itself so a coincident
    // completion report is refused that same cycle and retried.
    assign err_pending = (state_q == S_CHECK) && !chk_match;

    // Abandon: no first beat within the window, or the beat burst broke early.
    assign tmo_hit = ((state_q == S_WAIT_OE) && !cmd_oe && (tmo_q == TW'(OE_TIMEOUT - 1))) ||
                     ((state_q == S_CAP) && !cmd_oe);

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        beat_d  = beat_q;
        cdb_d   = cdb_q;
        case (state_q)
            S_IDLE: begin
                if (cq_cout_ready) state_d = S_REQ;
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT_OE;
            end
            S_WAIT_OE: begin
                if (cmd_oe) begin
                    cdb_d[CMD_IO_WIDTH-1:0] = cmd_out;
                    beat_d  = 2'd1;
                    state_d = S_CAP;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end else if (tmo_q != TW'(OE_TIMEOUT)) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CAP: begin
                if (!cmd_oe) begin
                    beat_d  = 2'd0;
                    state_d = S_IDLE;
                end else begin
                    for (int b = 1; b < CDB_BEATS; b++) begin
                        if (beat_q == 2'(b)) cdb_d[b*CMD_IO_WIDTH +: CMD_IO_WIDTH] = cmd_out;
                    end
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = S_CHECK;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            S_CHECK: begin
                state_d = chk_match ? S_PRESENT : S_IDLE;
            end
            S_PRESENT: begin
                if (dec_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status writeback runs alongside the FSM; error beats a completion report.
    always_comb begin
        idx_d = '0;
        st_d  = CMD_ST_NONE;
        if (err_pending) begin
            idx_d = cdb_q[TAG_LSB +: FIELD_W];
            st_d  = CMD_ST_CHKSUM_ERR;
        end else if (done_valid && done_ready) begin
            idx_d = done_tag;
            st_d  = done_status;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            beat_q  <= '0;
            cdb_q   <= '0;
            idx_q   <= '0;
            st_q    <= CMD_ST_NONE;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            beat_q  <= beat_d;
            cdb_q   <= cdb_d;
            idx_q   <= idx_d;
            st_q    <= st_d;
        end
    end

    assign cmd_request   = (state_q == S_REQ);
    assign dec_valid     = (state_q == S_PRESENT);
    assign dec_cdb       = cdb_q;
    assign dec_opcode    = cdb_q[OPC_LSB +: FIELD_W];
    assign dec_tag       = cdb_q[TAG_LSB +: FIELD_W];
    assign op_index      = idx_q;
    assign cmd_op_status = st_q;
    assign done_ready    = !reset && !err_pending;
    assign timeout       = tmo_hit && !reset;

endmodule

// File: tb/tb_hv_cmd_fetch.sv
module tb_hv_cmd_fetch;
    import hv_cmd_pkg::*;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cq_cout_ready = 1'b0;
    logic         cmd_oe = 1'b0;
    logic [63:0]  cmd_out = '0;
    logic         dec_ready = 1'b0;
    logic         done_valid = 1'b0;
    logic [7:0]   done_tag = '0;
    logic [7:0]   done_status = '0;
    logic         cmd_request, dec_valid, done_ready, timeout;
    logic [7:0]   op_index, cmd_op_status, dec_opcode, dec_tag;
    logic [255:0] dec_cdb;

    hv_cmd_fetch #(.CMD_IO_WIDTH(64), .OE_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cq_cout_ready(cq_cout_ready),
        .cmd_request(cmd_request), .cmd_oe(cmd_oe), .cmd_out(cmd_out),
        .op_index(op_index), .cmd_op_status(cmd_op_status),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
        .dec_tag(dec_tag), .dec_cdb(dec_cdb), .done_valid(done_valid),
        .done_tag(done_tag), .done_status(done_status), .done_ready(done_ready),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // queue model contents and scoreboards
    logic [255:0] mq[$];
    logic [255:0] exp_dec[$];
    logic [15:0]  exp_st[$];
    int           st_cyc[$];

    int req_cnt = 0, rise_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, rise_cyc = 0;
    int last_xfer = 0, beat0_cyc = 0, serve_req_cyc = 0, hold_until = 0;
    bit prev_dv = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference checksum: byte lane by byte lane over every word but word 4.
    function automatic logic [31:0] ref_chk(input logic [255:0] c);
        logic [31:0] x;
        logic [7:0]  b;
        x = '0;
        for (int lane = 0; lane < 4; lane++) begin
            b = '0;
            for (int w = 0; w < 8; w++)
                if (w != 4) b = b ^ c[w*32 + lane*8 +: 8];
            x[lane*8 +: 8] = b;
        end
        return x;
    endfunction

    function automatic logic [255:0] mk_cdb(input logic [7:0] op, input logic [7:0] tag);
        logic [255:0] c;
        for (int w = 0; w < 8; w++) c[w*32 +: 32] = $urandom;
        c[7:0]     = op;
        c[15:8]    = tag;
        c[159:128] = ref_chk(c);
        return c;
    endfunction

    task automatic enq(input logic [255:0] c, input bit expect_it);
        mq.push_back(c);
        cq_cout_ready = 1'b1;
        if (expect_it) begin
            if (ref_chk(c) == c[159:128]) exp_dec.push_back(c);
            else exp_st.push_back({c[15:8], CMD_ST_CHKSUM_ERR});
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_cmd_request"}, cmd_request, 0);
        chk({p, "_op_index"}, op_index, 0);
        chk({p, "_cmd_op_status"}, cmd_op_status, 0);
        chk({p, "_dec_valid"}, dec_valid, 0);
        chk({p, "_dec_opcode"}, dec_opcode, 0);
        chk({p, "_dec_tag"}, dec_tag, 0);
        chk({p, "_dec_cdb"}, dec_cdb, 0);
        chk({p, "_done_ready"}, done_ready, 0);
        chk({p, "_timeout"}, timeout, 0);
    endtask

    // Queue-side behaviour. mode 0: normal, 1: never answer,
    // 2: reset after beat 1, 3: send a completion report into the CHECK cycle.
    task automatic serve(input int mode);
        bit got;
        bit acc;
        logic [255:0] c;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_request) got = 1'b1;
        end
        chk("req_seen", got, 1);
        if (!got) return;
        serve_req_cyc = cyc;
        if (mode == 1) return;
        c = mq.pop_front();
        cq_cout_ready = (mq.size() != 0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            if (mode == 2 && b == 2) break;
            @(posedge clk); #1;
            cmd_oe = 1'b1;
            cmd_out = c[b*64 +: 64];
            if (b == 0) beat0_cyc = cyc;
        end
        @(posedge clk); #1;
        cmd_oe = 1'b0;
        cmd_out = {$urandom, $urandom};
        if (mode == 2) begin
            reset = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check_reset_vals("midreset");
            @(posedge clk); #1;
            reset = 1'b0;
        end else if (mode == 3) begin
            done_valid = 1'b1;
            done_tag = 8'h09;
            done_status = CMD_ST_READ_DONE;
            @(negedge clk);
            chk("collide_done_ready", done_ready, 0);
            acc = 1'b0;
            for (int i = 0; i < 10 && !acc; i++) begin
                @(negedge clk);
                if (done_ready) acc = 1'b1;
            end
            chk("collide_retry_acc", acc, 1);
            if (acc) exp_st.push_back({8'h09, CMD_ST_READ_DONE});
            @(posedge clk); #1;
            done_valid = 1'b0;
        end
    endtask

    task automatic send_done(input logic [7:0] tag, input logic [7:0] st);
        bit acc;
        acc = 1'b0;
        done_valid = 1'b1;
        done_tag = tag;
        done_status = st;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (done_ready) acc = 1'b1;
        end
        chk("done_acc", acc, 1);
        if (acc) exp_st.push_back({tag, st});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (exp_dec.size() != 0 || exp_st.size() != 0); i++)
            @(negedge clk);
        chk("drain_dec", exp_dec.size(), 0);
        chk("drain_st", exp_st.size(), 0);
        exp_dec.delete();
        exp_st.delete();
    endtask

    // downstream acceptance: random, with an optional hold-off window
    initial forever begin
        @(posedge clk); #1;
        dec_ready = (cyc >= hold_until) && ($urandom_range(0, 3) != 0);
    end

    // monitor / scoreboard
    initial forever begin
        logic [255:0] e;
        logic [15:0]  s;
        @(negedge clk);
        if (!reset) begin
            if (dec_valid && !prev_dv) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (cmd_request) begin
                req_cnt++;
                chk("req_while_valid", dec_valid, 0);
            end
            if (timeout) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
            if (dec_valid && dec_ready) begin
                last_xfer = cyc;
                if (exp_dec.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dec_extra got_tag=%0h want=none", dec_tag);
                end else begin
                    e = exp_dec.pop_front();
                    chk("dec_cdb", dec_cdb, e);
                    chk("dec_opcode", dec_opcode, e[7:0]);
                    chk("dec_tag", dec_tag, e[15:8]);
                end
            end
            if (cmd_op_status != CMD_ST_NONE) begin
                st_cyc.push_back(cyc);
                if (exp_st.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL st_extra got=%0h/%0h want=none", op_index, cmd_op_status);
                end else begin
                    s = exp_st.pop_front();
                    chk("status_write", {op_index, cmd_op_status}, s);
                end
            end
        end
        prev_dv = dec_valid;
    end

    initial begin
        logic [255:0] c;
        int r0, k0, t0, rq;
        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("done_ready_idle", done_ready, 1);

        // basic BSM_WRITE, tag 2
        c = '0;
        c[63:0]    = 64'h240;
        c[191:128] = 64'h240;
        r0 = req_cnt;
        enq(c, 1);
        serve(0);
        drain();
        chk("t1_req_pulses", req_cnt - r0, 1);
        chk("t1_latency", rise_cyc - beat0_cyc, 5);

        // same CDB with a corrupted checksum byte
        c[135:128] = 8'h41;
        k0 = rise_cnt;
        enq(c, 1);
        serve(0);
        drain();
        chk("t2_no_present", rise_cnt - k0, 0);

        // three queued, first held off downstream
        hold_until = cyc + 30;
        for (int t = 0; t < 3; t++) enq(mk_cdb(OP_BSM_READ, 8'(t)), 1);
        serve(0);
        serve(0);
        chk("t3_req_after_xfer", serve_req_cyc > last_xfer, 1);
        serve(0);
        drain();

        // no beats at all -> timeout, then a retry
        t0 = tmo_cnt;
        enq(mk_cdb(OP_QUERY, 8'h33), 1);
        serve(1);
        rq = serve_req_cyc;
        for (int i = 0; i < TMO + 20 && tmo_cnt == t0; i++) @(negedge clk);
        chk("t4_timeout_seen", tmo_cnt - t0, 1);
        chk("t4_timeout_at", tmo_cyc - rq, TMO);
        serve(0);
        drain();
        chk("t4_single_timeout", tmo_cnt - t0, 1);

        // back-to-back completion reports
        st_cyc.delete();
        @(posedge clk); #1;
        send_done(8'h05, CMD_ST_WRITE_DONE);
        send_done(8'h05, CMD_ST_WRITE_DONE);
        send_done(8'h06, CMD_ST_READY2FREE);
        done_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_status_cleared", cmd_op_status, 0);
        chk("t5_status_count", st_cyc.size(), 3);
        if (st_cyc.size() == 3) begin
            chk("t5_b2b_1", st_cyc[1] - st_cyc[0], 1);
            chk("t5_b2b_2", st_cyc[2] - st_cyc[0], 2);
        end
        drain();

        // reset in the middle of a CDB, then a clean one
        enq(mk_cdb(OP_BSM_WRITE, 8'h44), 0);
        enq(mk_cdb(OP_BSM_WRITE, 8'h45), 1);
        serve(2);
        serve(0);
        drain();

        // checksum error colliding with a completion report
        c = mk_cdb(OP_BSM_READ, 8'h0B);
        c[40] = ~c[40];
        st_cyc.delete();
        enq(c, 1);
        serve(3);
        drain();
        chk("t7_status_count", st_cyc.size(), 2);
        if (st_cyc.size() == 2) chk("t7_b2b", st_cyc[1] - st_cyc[0], 1);

        // randomized traffic, roughly a quarter corrupted
        for (int n = 0; n < 16; n++) begin
            c = mk_cdb(8'($urandom_range(0, 255)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) c[$urandom_range(0, 255)] ^= 1'b1;
            enq(c, 1);
            serve(0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
